pu_msp430_alu_rpt: RTL



---
 rtl/pu_msp430_alu_rpt_pkg.sv | 59 +++++
 rtl/pu_msp430_alu_rpt.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pu_msp430_alu_rpt_pkg.sv
// Shared types and ALU control encodings for the shift/rotate repeat sequencer.
// Bit positions match the core ALU control vector (inst_alu) and single-operand decode (inst_so).
package pu_msp430_alu_rpt_pkg;

    localparam int ALU_INC_C  = 2;
    localparam int ALU_ADD    = 3;
    localparam int ALU_STAT_F = 9;
    localparam int ALU_SHIFT  = 10;

    localparam int SO_RRC = 0;
    localparam int SO_RRA = 2;

    typedef enum logic [1:0] {
        OP_RRA = 2'd0,
        OP_RRC = 2'd1,
        OP_RLA = 2'd2,
        OP_RLC = 2'd3
    } rpt_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rpt_state_e;

    typedef struct packed {
        logic [11:0] inst_alu;
        logic [7:0]  inst_so;
        logic        dst_is_acc;
    } alu_ctrl_t;

    // Left shifts are performed as acc+acc (plus carry for RLC) through the adder.
    function automatic alu_ctrl_t op_decode(rpt_op_e op);
        alu_ctrl_t c;
        c = '0;
        c.inst_alu[ALU_STAT_F] = 1'b1;
        case (op)
            OP_RRA: begin
                c.inst_alu[ALU_SHIFT] = 1'b1;
                c.inst_so[SO_RRA]     = 1'b1;
            end
            OP_RRC: begin
                c.inst_alu[ALU_SHIFT] = 1'b1;
                c.inst_so[SO_RRC]     = 1'b1;
            end
            OP_RLA: begin
                c.inst_alu[ALU_ADD] = 1'b1;
                c.dst_is_acc        = 1'b1;
            end
            default: begin
                c.inst_alu[ALU_ADD]   = 1'b1;
                c.inst_alu[ALU_INC_C] = 1'b1;
                c.dst_is_acc          = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pu_msp430_alu_rpt.sv
// Repeat sequencer: drives the core ALU for 1..2^CNT_W back-to-back shift/rotate iterations.
// Optional PU_MSP430_ALU_RPT_EARLY_EXIT_EN stops as soon as data and flags reach a fixed point.
module pu_msp430_alu_rpt
    import pu_msp430_alu_rpt_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             mclk,
    input  logic             puc_rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [CNT_W-1:0] req_cnt,
    input  logic             req_bw,
    input  logic [15:0]      req_data,
    input  logic [3:0]       req_stat,
    input  logic             abort,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic [3:0]       rsp_stat,
    output logic [CNT_W:0]   rsp_iter,
    output logic             alu_exec_cycle,
    output logic [11:0]      alu_inst_alu,
    output logic [7:0]       alu_inst_so,
    output logic             alu_inst_bw,
    output logic [15:0]      alu_op_src,
    output logic [15:0]      alu_op_dst,
    output logic [3:0]       alu_status,
    input  logic [15:0]      alu_out,
    input  logic [3:0]       alu_stat,
    input  logic [3:0]       alu_stat_wr
);

    rpt_state_e       state, state_nxt;
    rpt_op_e          op_q;
    logic             bw_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   iter;
    logic [15:0]      acc, acc_nxt;
    logic [3:0]       sreg, sreg_nxt;
    logic             accept, last, run_exit;
    alu_ctrl_t        ctrl;

    assign ctrl    = op_decode(op_q);
    assign accept  = (state == ST_IDLE) && req_valid && !abort;
    assign last    = (iter == {1'b0, cnt_q});
    assign acc_nxt = bw_q ? {8'h00, alu_out[7:0]} : alu_out;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sreg_nxt[i] = alu_stat_wr[i] ? alu_stat[i] : sreg[i];
        end
    end

`ifdef PU_MSP430_ALU_RPT_EARLY_EXIT_EN
    assign run_exit = last || ((acc_nxt == acc) && (sreg_nxt == sreg));
`else
    assign run_exit = last;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)         state_nxt = ST_IDLE;
                else if (run_exit) state_nxt = ST_DONE;
            end
            ST_DONE: if (abort || rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control state
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state <= ST_IDLE;
            op_q  <= OP_RRA;
            bw_q  <= 1'b0;
            cnt_q <= '0;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= rpt_op_e'(req_op);
                bw_q  <= req_bw;
                cnt_q <= req_cnt;
                iter  <= '0;
            end else if (state == ST_RUN && !abort) begin
                iter <= iter + (CNT_W+1)'(1);
            end
        end
    end

    // Datapath: operand and flag accumulators
    always_ff @(posedge mclk) begin
        if (accept) begin
            acc  <= req_bw ? {8'h00, req_data[7:0]} : req_data;
            sreg <= req_stat;
        end else if (state == ST_RUN) begin
            acc  <= acc_nxt;
            sreg <= sreg_nxt;
        end
    end

    always_comb begin
        req_ready      = (state == ST_IDLE);
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        rsp_stat       = '0;
        rsp_iter       = '0;
        alu_exec_cycle = 1'b0;
        alu_inst_alu   = '0;
        alu_inst_so    = '0;
        alu_inst_bw    = 1'b0;
        alu_op_src     = '0;
        alu_op_dst     = '0;
        alu_status     = '0;
        if (state == ST_RUN) begin
            alu_exec_cycle = 1'b1;
            alu_inst_alu   = ctrl.inst_alu;
            alu_inst_so    = ctrl.inst_so;
            alu_inst_bw    = bw_q;
            alu_op_src     = acc;
            alu_op_dst     = ctrl.dst_is_acc ? acc : 16'h0000;
            alu_status     = sreg;
        end else if (state == ST_DONE) begin
            rsp_valid = 1'b1;
            rsp_data  = acc;
            rsp_stat  = sreg;
            rsp_iter  = iter;
        end
    end

endmodule
